uart_tx: RTL and testbench

UART transmitter stage that produces the serial stream consumed by uart_rx on the far end of the link.
- Buffers bytes from a local producer in a 16-entry FIFO.
- Serialises each byte as an 11-bit frame: start, 8 data bits LSB first, parity, stop.
- Default line rate is 115200 baud from the 100 MHz sys_clk (868 clocks per bit), matching the receiver's frame format.

---
 rtl/uart_tx.sv | 116 +++++++++++
 tb/tb_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 16-entry byte FIFO feeding an 11-bit frame serialiser
// (start, 8 data bits LSB first, parity, stop) with a registered line output.
module uart_tx #(
    parameter int BAUD_CNT    = 868,
    parameter int PARITY_TYPE = 1,
    parameter int FIFO_DEPTH  = 16,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        data_out,
    output logic        tx_busy,
    output logic [AW:0] fifo_count
);

    localparam int           CW        = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PTR_ONE  = CW'(1);
    localparam logic [9:0]   BAUD_LAST = 10'(BAUD_CNT - 1);
    localparam logic         PAR_BIT   = 1'(PARITY_TYPE);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t         state_q, state_d;
    logic [AW:0]    wr_ptr_q, rd_ptr_q;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     byte_q;
    logic [10:0]    frame_q, frame_d;
    logic [9:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic           data_out_q, data_out_d;
    logic           push, pop;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign tx_ready   = (fifo_count != FULL_CNT);
    assign push       = tx_valid && tx_ready;
    assign data_out   = data_out_q;
    assign tx_busy    = (state_q != IDLE) || (fifo_count != '0);

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            byte_q     <= '0;
            state_q    <= IDLE;
            frame_q    <= '1;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                byte_q   <= mem_q[rd_ptr_q[AW-1:0]];
            end
            state_q    <= state_d;
            frame_q    <= frame_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_out_d = 1'b1;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                frame_d   = {1'b1, (^byte_q) ^ PAR_BIT, byte_q, 1'b0};
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                state_d   = SEND;
            end
            SEND: begin
                data_out_d = frame_q[0];
                if (clk_cnt_q == BAUD_LAST) begin
                    clk_cnt_d = '0;
                    frame_d   = {1'b1, frame_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    // Stop bit done: chain straight into the next byte if one is queued.
                    if (bit_cnt_q == 4'd10) begin
                        bit_cnt_d = '0;
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_CNT=16 with an odd- and an even-parity instance.
module tb_uart_tx;

    localparam int B = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] tx_data, tx_data_e;
    logic       tx_valid, tx_valid_e;
    logic       tx_ready, tx_ready_e;
    logic       data_out, data_out_e;
    logic       tx_busy, tx_busy_e;
    logic [4:0] fifo_count, fifo_count_e;

    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    uart_tx #(.BAUD_CNT(B), .PARITY_TYPE(1), .FIFO_DEPTH(16)) u_odd (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .data_out(data_out), .tx_busy(tx_busy), .fifo_count(fifo_count));

    uart_tx #(.BAUD_CNT(B), .PARITY_TYPE(0), .FIFO_DEPTH(16)) u_even (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tx_data(tx_data_e), .tx_valid(tx_valid_e),
        .tx_ready(tx_ready_e), .data_out(data_out_e), .tx_busy(tx_busy_e), .fifo_count(fifo_count_e));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic steps(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push(input logic [7:0] b, input bit both);
        tx_data  = b;
        tx_valid = 1'b1;
        if (both) begin
            tx_data_e  = b;
            tx_valid_e = 1'b1;
        end
        steps(1);
        tx_valid   = 1'b0;
        tx_valid_e = 1'b0;
    endtask

    // Waits for the odd instance's start bit, then checks every cycle of all 11 bits on both lines.
    task automatic check_frame(input string tag, input logic [10:0] exp_o, input logic [10:0] exp_e);
        logic [15:0] vo, ve;
        int n = 0;
        while (data_out !== 1'b0 && n < 400) begin n++; steps(1); end
        if (n >= 400) begin chk({tag, "_timeout"}, 1, 0); return; end
        for (int k = 0; k < 11; k++) begin
            for (int c = 0; c < B; c++) begin
                vo[c] = data_out;
                ve[c] = data_out_e;
                if (k*B + c == 174) chk({tag, "_busy_hi"}, tx_busy, 1);
                if (k*B + c == 175) chk({tag, "_busy_lo"}, tx_busy, 0);
                steps(1);
            end
            chk($sformatf("%s_o_bit%0d", tag, k), vo, {16{exp_o[k]}});
            chk($sformatf("%s_e_bit%0d", tag, k), ve, {16{exp_e[k]}});
        end
    endtask

    // Mid-bit decoder on the odd line; returns at the middle of the stop bit.
    task automatic rx(output logic [7:0] d, output logic par, output logic stp);
        int n = 0;
        d = '0; par = 1'b0; stp = 1'b0;
        while (data_out !== 1'b0 && n < 2000) begin n++; steps(1); end
        if (n >= 2000) begin chk("rx_timeout", 1, 0); return; end
        steps(B/2);
        chk("rx_start_mid", data_out, 0);
        for (int k = 0; k < 10; k++) begin
            steps(B);
            if (k < 8) d[k] = data_out;
            else if (k == 8) par = data_out;
            else stp = data_out;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;
        int         peak, lows, gap;
        logic [7:0] pp_bytes [7];

        sys_rst_n = 1'b0;
        tx_data = '0; tx_valid = 1'b0; tx_data_e = '0; tx_valid_e = 1'b0;
        steps(2);
        chk("rst_data_out", data_out, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        sys_rst_n = 1'b1;
        steps(2);

        // Single byte 0x55: latency then exact frame; odd parity of four ones is 1.
        push(8'h55, 1'b0);
        chk("lat_n0", data_out, 1);
        steps(1); chk("lat_n1", data_out, 1);
        steps(1); chk("lat_n2", data_out, 1);
        steps(1); chk("lat_n3_start", data_out, 0);
        check_frame("b55", 11'b1_1_01010101_0, 11'b111_1111_1111);

        // Parity modes: 0x00 and 0xFF -> odd gives 1,1 ; even gives 0,0.
        push(8'h00, 1'b1);
        check_frame("p00", 11'b1_1_00000000_0, 11'b1_0_00000000_0);
        push(8'hFF, 1'b1);
        check_frame("pFF", 11'b1_1_11111111_0, 11'b1_0_11111111_0);

        // Back-to-back 0xA3, 0x3C: one extra high cycle after the stop bit.
        push(8'hA3, 1'b0);
        push(8'h3C, 1'b0);
        rx(d, p, s);
        chk("b2b_d0", d, 8'hA3); chk("b2b_p0", p, 1); chk("b2b_s0", s, 1);
        gap = 0;
        while (data_out === 1'b1 && gap < 100) begin gap++; steps(1); end
        chk("b2b_gap", gap, B/2 + 1);
        rx(d, p, s);
        chk("b2b_d1", d, 8'h3C); chk("b2b_p1", p, 1); chk("b2b_s1", s, 1);
        steps(B);

        // Fill to full with continuous valid; 0x10 must land once space exists, 0x77 must not.
        peak = 0;
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    int g = 0;
                    tx_data  = 8'(i);
                    tx_valid = 1'b1;
                    while (!tx_ready && g < 4000) begin g++; steps(1); end
                    steps(1);
                    if (fifo_count > peak) peak = fifo_count;
                end
                chk("fill_peak", peak, 16);
                chk("fill_ready", tx_ready, 0);
                tx_data = 8'h77;
                steps(3);
                chk("fill_ignore_cnt", fifo_count, 16);
                tx_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    logic [7:0] rd;
                    logic rp, rs;
                    rx(rd, rp, rs);
                    chk($sformatf("fill_d%0d", i), rd, 8'(i));
                    chk($sformatf("fill_p%0d", i), rp, ~^rd);
                    chk($sformatf("fill_s%0d", i), rs, 1);
                end
            end
        join
        steps(20);
        chk("fill_busy_end", tx_busy, 0);
        chk("fill_cnt_end", fifo_count, 0);
        lows = 0;
        for (int i = 0; i < 300; i++) begin if (data_out !== 1'b1) lows++; steps(1); end
        chk("fill_no_extra", lows, 0);

        // Simultaneous push/pop at count 5 on the frame-ending edge.
        pp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'hE7};
        fork
            begin
                for (int i = 0; i < 6; i++) push(pp_bytes[i], 1'b0);
                steps(172);
                chk("pp_pre_cnt", fifo_count, 5);
                tx_data  = 8'hE7;
                tx_valid = 1'b1;
                steps(1);
                tx_valid = 1'b0;
                chk("pp_post_cnt", fifo_count, 5);
            end
            begin
                for (int i = 0; i < 7; i++) begin
                    logic [7:0] rd;
                    logic rp, rs;
                    rx(rd, rp, rs);
                    chk($sformatf("pp_d%0d", i), rd, pp_bytes[i]);
                end
            end
        join
        steps(20);

        // Reset during frame bit 4 of 0x81 (a low bit) with three bytes queued.
        push(8'h81, 1'b0);
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        push(8'h03, 1'b0);
        chk("mr_start", data_out, 0);
        chk("mr_cnt", fifo_count, 3);
        steps(66);
        chk("mr_pre_bit4", data_out, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("mr_data_out", data_out, 1);
        chk("mr_cnt0", fifo_count, 0);
        chk("mr_ready", tx_ready, 1);
        chk("mr_busy", tx_busy, 0);
        steps(3);
        sys_rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin if (data_out !== 1'b1 || tx_busy !== 1'b0) lows++; steps(1); end
        chk("mr_no_frame", lows, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
